alu_datapath: RTL and testbench

//  Single-cycle MIPS-subset CPU core: PC, 32x32 register file, decoder, ALU, writeback mux.

---
 rtl/alu_datapath.sv | 170 +++++++++++++++++
 tb/tb_alu_datapath.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_datapath.sv
// Single-cycle MIPS-subset core: PC, 32x32 register file, decoder, ALU and writeback mux.
// Optional feature macro: OVERFLOW_TRAP_EN (suppress add/addi/sub writeback on signed overflow).
module alu_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] readData,
  output logic [31:0] PC,
  output logic [31:0] ALUResult,
  output logic [31:0] writeData,
  output logic        memWrite
);
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111;
  localparam logic [5:0] F_JR   = 6'b001000, F_ADD  = 6'b100000, F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010, F_SUBU = 6'b100011, F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101, F_XOR  = 6'b100110, F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU = 6'b101011;

  localparam logic [1:0] RES_ALU = 2'd0, RES_MEM = 2'd1, RES_LINK = 2'd2;

  logic [31:0] gr [0:31];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, dest;
  logic [15:0] imm;
  logic [31:0] srcA, srcB, rt_val, sext_imm, zext_imm, ext_imm;
  logic [31:0] sum, diff, pc_plus4, branch_target, jump_target, next_pc, result;
  logic [1:0]  res_sel;
  logic        regWrite;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};
  assign ext_imm  = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? zext_imm : sext_imm;

  // gr[0] is reset to zero and never written, so reading it always yields zero.
  assign srcA   = gr[rs];
  assign rt_val = gr[rt];
  assign srcB   = (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE) ? rt_val : ext_imm;

  assign sum           = srcA + srcB;
  assign diff          = srcA - srcB;
  assign pc_plus4      = PC + 32'd4;
  assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

`ifdef OVERFLOW_TRAP_EN
  logic add_ovf, sub_ovf, overflow;
  assign add_ovf = (srcA[31] == srcB[31]) && (sum[31] != srcA[31]);
  assign sub_ovf = (srcA[31] != srcB[31]) && (diff[31] != srcA[31]);
`endif

  always_comb begin
    ALUResult = '0;
    regWrite  = 1'b0;
    memWrite  = 1'b0;
    dest      = rd;
    res_sel   = RES_ALU;
    next_pc   = pc_plus4;
`ifdef OVERFLOW_TRAP_EN
    overflow  = 1'b0;
`endif
    case (op)
      OP_RTYPE: begin
        regWrite = 1'b1;
        case (funct)
          F_ADD: begin
            ALUResult = sum;
`ifdef OVERFLOW_TRAP_EN
            overflow = add_ovf;
`endif
          end
          F_ADDU: ALUResult = sum;
          F_SUB: begin
            ALUResult = diff;
`ifdef OVERFLOW_TRAP_EN
            overflow = sub_ovf;
`endif
          end
          F_SUBU: ALUResult = diff;
          F_AND:  ALUResult = srcA & srcB;
          F_OR:   ALUResult = srcA | srcB;
          F_XOR:  ALUResult = srcA ^ srcB;
          F_NOR:  ALUResult = ~(srcA | srcB);
          F_SLT:  ALUResult = {31'b0, $signed(srcA) < $signed(srcB)};
          F_SLTU: ALUResult = {31'b0, srcA < srcB};
          F_SLL:  ALUResult = rt_val << shamt;
          F_SRL:  ALUResult = rt_val >> shamt;
          F_SRA:  ALUResult = $signed(rt_val) >>> shamt;
          F_SLLV: ALUResult = rt_val << srcA[4:0];
          F_SRLV: ALUResult = rt_val >> srcA[4:0];
          F_SRAV: ALUResult = $signed(rt_val) >>> srcA[4:0];
          F_JR: begin
            regWrite = 1'b0;
            next_pc  = srcA;
          end
          default: regWrite = 1'b0;
        endcase
      end
      OP_ADDI: begin
        dest      = rt;
        regWrite  = 1'b1;
        ALUResult = sum;
`ifdef OVERFLOW_TRAP_EN
        overflow  = add_ovf;
`endif
      end
      OP_ADDIU: begin dest = rt; regWrite = 1'b1; ALUResult = sum; end
      OP_SLTI:  begin dest = rt; regWrite = 1'b1; ALUResult = {31'b0, $signed(srcA) < $signed(srcB)}; end
      OP_SLTIU: begin dest = rt; regWrite = 1'b1; ALUResult = {31'b0, srcA < srcB}; end
      OP_ANDI:  begin dest = rt; regWrite = 1'b1; ALUResult = srcA & srcB; end
      OP_ORI:   begin dest = rt; regWrite = 1'b1; ALUResult = srcA | srcB; end
      OP_XORI:  begin dest = rt; regWrite = 1'b1; ALUResult = srcA ^ srcB; end
      OP_LUI:   begin dest = rt; regWrite = 1'b1; ALUResult = {imm, 16'h0000}; end
      OP_LW: begin
        dest      = rt;
        regWrite  = 1'b1;
        ALUResult = sum;
        res_sel   = RES_MEM;
      end
      OP_SW: begin
        ALUResult = sum;
        memWrite  = 1'b1;
      end
      OP_BEQ: if (srcA == srcB) next_pc = branch_target;
      OP_BNE: if (srcA != srcB) next_pc = branch_target;
      OP_J:   next_pc = jump_target;
      OP_JAL: begin
        dest     = 5'd31;
        regWrite = 1'b1;
        res_sel  = RES_LINK;
        next_pc  = jump_target;
      end
      default: ;
    endcase
`ifdef OVERFLOW_TRAP_EN
    if (overflow) regWrite = 1'b0;
`endif
  end

  assign result    = (res_sel == RES_MEM)  ? readData :
                     (res_sel == RES_LINK) ? pc_plus4 : ALUResult;
  assign writeData = rt_val;

  always_ff @(posedge clock) begin
    if (reset) begin
      PC <= RESET_PC;
      for (int i = 0; i < 32; i++) gr[i] <= '0;
    end else begin
      PC <= next_pc;
      if (regWrite && dest != 5'd0) gr[dest] <= result;
    end
  end
endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: directed program steps, then random instructions
// checked against an instruction-level reference model of the architectural state.
module tb_alu_datapath;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr, readData, PC, ALUResult, writeData;
  logic        memWrite;

  always #5 clock = ~clock;

  alu_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .instr(instr), .readData(readData),
    .PC(PC), .ALUResult(ALUResult), .writeData(writeData), .memWrite(memWrite)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_gr [32];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"}, PC, m_pc);
    for (int i = 0; i < 32; i++) check($sformatf("%s_gr%0d", tag, i), dut.gr[i], m_gr[i]);
  endtask

  task automatic do_reset(input logic [31:0] ins);
    @(negedge clock);
    reset = 1'b1; instr = ins; readData = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_gr[i] = 32'h0;
    check_state("reset");
    reset = 1'b0;
    $display("reset instr=%h pc=%h", ins, PC);
  endtask

  // Reference model: architectural effect of one instruction, then compare DUT before and after the edge.
  task automatic step(input logic [31:0] ins, input logic [31:0] rdata);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, dst;
    logic [31:0] a, b, simm, zimm, sb, alu, res, npc, p4;
    bit          we, mw, chk_alu, ovf;
    longint      wide;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    a = m_gr[rs]; b = m_gr[rt]; p4 = m_pc + 32'd4;
    simm = {{16{ins[15]}}, ins[15:0]}; zimm = {16'h0, ins[15:0]};
    we = 0; mw = 0; chk_alu = 1; ovf = 0; dst = rd; alu = 0; npc = p4; sb = simm; wide = 0;
    if (op == 6'h00) begin
      we = 1; sb = b;
      case (fn)
        6'h20: begin alu = a + b; wide = longint'($signed(a)) + longint'($signed(b)); ovf = wide != longint'($signed(alu)); end
        6'h21: alu = a + b;
        6'h22: begin alu = a - b; wide = longint'($signed(a)) - longint'($signed(b)); ovf = wide != longint'($signed(alu)); end
        6'h23: alu = a - b;
        6'h24: alu = a & b;
        6'h25: alu = a | b;
        6'h26: alu = a ^ b;
        6'h27: alu = ~(a | b);
        6'h2a: alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2b: alu = (a < b) ? 32'd1 : 32'd0;
        6'h00: alu = b << sh;
        6'h02: alu = b >> sh;
        6'h03: alu = $signed(b) >>> sh;
        6'h04: alu = b << a[4:0];
        6'h06: alu = b >> a[4:0];
        6'h07: alu = $signed(b) >>> a[4:0];
        6'h08: begin we = 0; chk_alu = 0; npc = a; end
        default: begin we = 0; chk_alu = 0; end
      endcase
    end else begin
      dst = rt; we = 1;
      case (op)
        6'h08: begin alu = a + simm; wide = longint'($signed(a)) + longint'($signed(simm)); ovf = wide != longint'($signed(alu)); end
        6'h09: alu = a + simm;
        6'h0a: alu = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
        6'h0b: alu = (a < simm) ? 32'd1 : 32'd0;
        6'h0c: begin alu = a & zimm; sb = zimm; end
        6'h0d: begin alu = a | zimm; sb = zimm; end
        6'h0e: begin alu = a ^ zimm; sb = zimm; end
        6'h0f: alu = {ins[15:0], 16'h0};
        6'h23: alu = a + simm;
        6'h2b: begin alu = a + simm; we = 0; mw = 1; end
        6'h04: begin we = 0; chk_alu = 0; if (a == b) npc = p4 + (simm << 2); end
        6'h05: begin we = 0; chk_alu = 0; if (a != b) npc = p4 + (simm << 2); end
        6'h02: begin we = 0; chk_alu = 0; npc = {p4[31:28], ins[25:0], 2'b00}; end
        6'h03: begin chk_alu = 0; dst = 5'd31; npc = {p4[31:28], ins[25:0], 2'b00}; end
        default: begin we = 0; chk_alu = 0; end
      endcase
    end
    res = (op == 6'h23) ? rdata : (op == 6'h03) ? p4 : alu;
`ifdef OVERFLOW_TRAP_EN
    if (ovf) we = 0;
`endif
    @(negedge clock);
    instr = ins; readData = rdata;
    #2;
    check("pc_now", PC, m_pc);
    check("srcA", dut.srcA, a);
    check("writeData", writeData, b);
    check("memWrite", {31'b0, memWrite}, {31'b0, mw});
    check("regWrite", {31'b0, dut.regWrite}, {31'b0, we});
    if (chk_alu) check("ALUResult", ALUResult, alu);
    if (chk_alu && op != 6'h0f) check("srcB", dut.srcB, sb);
    if (we) check("result", dut.result, res);
    @(posedge clock); #1;
    if (we && dst != 5'd0) m_gr[dst] = res;
    m_pc = npc;
    check_state("step");
    $display("step instr=%h readData=%h -> pc=%h ALUResult=%h", ins, rdata, PC, ALUResult);
  endtask

  logic [5:0]  r_fn [17];
  logic [5:0]  i_op [16];
  logic [31:0] rnd_ins;
  int          sel;

  initial begin
    r_fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
             6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
    i_op = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
             6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h23, 6'h09};
    reset = 1'b1; instr = 32'h0; readData = 32'h0;
    do_reset(32'h2005_0007);

    step(32'h8C01_0001, 32'h0000_00AB);
    check("lw_gr1", dut.gr[1], 32'h0000_00AB);
    step(32'h8C02_0002, 32'h0000_3C00);
    check("lw_gr2", dut.gr[2], 32'h0000_3C00);
    step(32'h0022_1820, 32'h0);
    check("add_gr3", dut.gr[3], 32'h0000_3CAB);
    step(32'hAC03_FFFF, 32'h1234_5678);
    check("sw_pc", PC, 32'h0000_0010);
    step(32'h1000_0003, 32'h0);
    check("beq_pc", PC, 32'h0000_0020);
    step(32'h1400_0003, 32'h0);
    check("bne_pc", PC, 32'h0000_0024);
    step(32'h2000_0005, 32'h0);
    check("gr0_zero", dut.gr[0], 32'h0);
    step(32'h3C01_7FFF, 32'h0);
    step(32'h3421_FFFF, 32'h0);
    check("gr1_max", dut.gr[1], 32'h7FFF_FFFF);
    step(32'h0021_2020, 32'h0);
`ifdef OVERFLOW_TRAP_EN
    check("ovf_gr4", dut.gr[4], 32'h0);
`else
    check("ovf_gr4", dut.gr[4], 32'hFFFF_FFFE);
`endif

    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 9);
      rnd_ins = $urandom;
      if (sel < 4) begin
        rnd_ins[31:26] = 6'h00;
        rnd_ins[5:0] = r_fn[$urandom_range(0, 16)];
      end else if (sel < 9) begin
        rnd_ins[31:26] = i_op[$urandom_range(0, 15)];
      end
      step(rnd_ins, $urandom);
    end

    // Reset while a taken jump and a register write are presented.
    do_reset(32'h0800_0040);
    do_reset(32'h2005_0007);
    step(32'h2005_0007, 32'h0);
    check("post_reset_gr5", dut.gr[5], 32'h0000_0007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
